// File: rtl/spi_result_tx_if.sv
// SPI-side signal bundle for the recognizer result transmitter.
// The host-facing receive path acts as master and the transmit controller acts as slave.
interface spi_result_tx_if #(
  parameter int WORD_W = 8
);
  logic              ss_n;
  logic              shift_spi;
  logic              sig_edge;
  logic [WORD_W-1:0] cmd_in;
  logic              cmd_valid;
  logic              miso;
  logic              miso_oe;

  modport master (
    output ss_n, shift_spi, sig_edge, cmd_in, cmd_valid,
    input  miso, miso_oe
  );

  modport slave (
    input  ss_n, shift_spi, sig_edge, cmd_in, cmd_valid,
    output miso, miso_oe
  );
endinterface

// File: rtl/spi_result_tx.sv
// SPI-slave transmit controller: buffers classified digits and answers host reads with
// digit, cost or status frames shifted out on miso, one or more words per frame.
module spi_result_tx #(
  parameter int WORD_W    = 8,
  parameter int DIGIT_W   = 4,
  parameter int COST_W    = 16,
  parameter int FIFO_D    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  spi_result_tx_if.slave            spi,
  input  logic                      network_done,
  input  logic [DIGIT_W-1:0]        digit_in,
  input  logic                      cost_valid,
  input  logic [COST_W-1:0]         cost_in,
  output logic [$clog2(FIFO_D):0]   fifo_cnt,
  output logic                      overflow
);

  localparam int NCW     = (COST_W + WORD_W - 1) / WORD_W;
  localparam int FRAME_W = NCW * WORD_W;
  localparam int BIT_CW  = $clog2(WORD_W);
  localparam int PTR_W   = $clog2(FIFO_D);
  localparam int CNT_W   = PTR_W + 1;
  localparam int WL_W    = $clog2(NCW + 1);

  localparam logic [WORD_W-1:0] CMD_RD_COST   = WORD_W'(1);
  localparam logic [WORD_W-1:0] CMD_RD_DIGIT  = WORD_W'(2);
  localparam logic [WORD_W-1:0] CMD_RD_STATUS = WORD_W'(3);
  localparam logic [WORD_W-1:0] CMD_CLR       = WORD_W'(4);

  typedef enum logic [1:0] {IDLE, WAIT_COST, LOAD, SEND} state_t;
  typedef enum logic [1:0] {K_COST, K_DIGIT, K_STATUS} kind_t;

  state_t              state, state_nxt;
  kind_t               kind, kind_sel;
  logic                ss_d, ss_rise;
  logic [BIT_CW-1:0]   bit_cnt;
  logic                boundary;
  logic [WORD_W-1:0]   shreg;
  logic [FRAME_W-1:0]  frame_buf, frame_full;
  logic [WL_W-1:0]     words_left;
  logic [WORD_W-1:0]   head_word, status_word;

  logic [DIGIT_W-1:0]  mem [FIFO_D];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                fifo_empty, fifo_full, push_ok;

  logic set_kind, clr_fifo, load_frame, next_word, shift_en, fill_ones, pop, cnt_clr;

  assign ss_rise    = spi.ss_n & ~ss_d;
  assign boundary   = spi.shift_spi && (bit_cnt == BIT_CW'(WORD_W - 1));
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == CNT_W'(FIFO_D));
  assign push_ok    = network_done && (!fifo_full || pop);
  assign fifo_cnt   = cnt;
  assign spi.miso   = MSB_FIRST ? shreg[WORD_W-1] : shreg[0];
  // The pad stays tri-stated while reset is held, even with the host selecting us.
  assign spi.miso_oe = ~spi.ss_n & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ss_d  <= 1'b1;
    end else begin
      state <= state_nxt;
      ss_d  <= spi.ss_n;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ss_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (spi.cmd_valid) begin
            if (spi.cmd_in == CMD_RD_COST)
              state_nxt = cost_valid ? LOAD : WAIT_COST;
            else if (spi.cmd_in == CMD_RD_DIGIT || spi.cmd_in == CMD_RD_STATUS)
              state_nxt = LOAD;
          end
        end
        WAIT_COST: begin
          if (cost_valid)    state_nxt = LOAD;
          else if (boundary) state_nxt = IDLE;
        end
        LOAD:    state_nxt = SEND;
        SEND:    if (boundary && words_left == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    set_kind   = 1'b0;
    kind_sel   = K_DIGIT;
    clr_fifo   = 1'b0;
    load_frame = 1'b0;
    next_word  = 1'b0;
    shift_en   = 1'b0;
    fill_ones  = 1'b0;
    cnt_clr    = 1'b0;
    // A popped digit is gone for good, even if the host aborts in this cycle.
    pop        = (state == LOAD) && (kind == K_DIGIT) && !fifo_empty;
    if (ss_rise) begin
      fill_ones = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          fill_ones = 1'b1;
          if (spi.cmd_valid) begin
            case (spi.cmd_in)
              CMD_RD_COST:   begin set_kind = 1'b1; kind_sel = K_COST;   end
              CMD_RD_DIGIT:  begin set_kind = 1'b1; kind_sel = K_DIGIT;  end
              CMD_RD_STATUS: begin set_kind = 1'b1; kind_sel = K_STATUS; end
              CMD_CLR:       clr_fifo = 1'b1;
              default:       ;
            endcase
          end
        end
        WAIT_COST: fill_ones = 1'b1;
        LOAD: begin
          load_frame = 1'b1;
          cnt_clr    = 1'b1;
        end
        SEND: begin
          if (boundary) begin
            if (words_left == '0) fill_ones = 1'b1;
            else                  next_word = 1'b1;
          end else if (spi.sig_edge) begin
            shift_en = 1'b1;
          end
        end
        default: fill_ones = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      kind    <= K_DIGIT;
    end else begin
      if (cnt_clr)            bit_cnt <= '0;
      else if (spi.shift_spi) bit_cnt <= boundary ? '0 : bit_cnt + BIT_CW'(1);
      if (set_kind) kind <= kind_sel;
    end
  end

  // Whole frame is built in one go; words leave from the top, most significant first.
  always_comb begin
    head_word   = fifo_empty ? '1 : WORD_W'(mem[rd_ptr]);
    status_word = WORD_W'(cnt);
    status_word[WORD_W-1] = overflow;
    status_word[WORD_W-2] = fifo_empty;
    case (kind)
      K_COST:   frame_full = FRAME_W'(cost_in);
      K_STATUS: frame_full = FRAME_W'(status_word) << (FRAME_W - WORD_W);
      default:  frame_full = FRAME_W'(head_word) << (FRAME_W - WORD_W);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '1;
      frame_buf  <= '0;
      words_left <= '0;
    end else if (fill_ones) begin
      shreg <= '1;
    end else if (load_frame) begin
      shreg      <= frame_full[FRAME_W-1 -: WORD_W];
      frame_buf  <= frame_full << WORD_W;
      words_left <= (kind == K_COST) ? WL_W'(NCW - 1) : '0;
    end else if (next_word) begin
      shreg      <= frame_buf[FRAME_W-1 -: WORD_W];
      frame_buf  <= frame_buf << WORD_W;
      words_left <= words_left - WL_W'(1);
    end else if (shift_en) begin
      shreg <= MSB_FIRST ? {shreg[WORD_W-2:0], 1'b1} : {1'b1, shreg[WORD_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clr_fifo) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!push_ok && pop) cnt <= cnt - CNT_W'(1);
      if (network_done && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_fifo) mem[wr_ptr] <= digit_in;
  end

endmodule

// File: tb/tb_spi_result_tx.sv
// Directed and randomized checks of spi_result_tx against a queue-based model of the
// digit FIFO and arithmetic frame expectations.
module tb_spi_result_tx;
  localparam int WORD_W  = 8;
  localparam int DIGIT_W = 4;
  localparam int COST_W  = 16;
  localparam int FIFO_D  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               network_done;
  logic [DIGIT_W-1:0] digit_in;
  logic               cost_valid;
  logic [COST_W-1:0]  cost_in;
  logic [2:0]         fifo_cnt;
  logic               overflow;

  spi_result_tx_if #(.WORD_W(WORD_W)) spi ();

  spi_result_tx #(
    .WORD_W(WORD_W), .DIGIT_W(DIGIT_W), .COST_W(COST_W), .FIFO_D(FIFO_D), .MSB_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .spi(spi), .network_done(network_done), .digit_in(digit_in),
    .cost_valid(cost_valid), .cost_in(cost_in), .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DIGIT_W-1:0] model_q[$];
  logic               model_ovf = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_digit(input logic [DIGIT_W-1:0] d);
    network_done = 1'b1;
    digit_in     = d;
    tick();
    network_done = 1'b0;
    if (model_q.size() < FIFO_D) model_q.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    spi.cmd_in    = c;
    spi.cmd_valid = 1'b1;
    tick();
    spi.cmd_valid = 1'b0;
  endtask

  // Host samples miso, then one sample edge and one shift edge arrive together.
  task automatic read_bits(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], spi.miso};
      spi.shift_spi = 1'b1;
      spi.sig_edge  = 1'b1;
      tick();
      spi.shift_spi = 1'b0;
      spi.sig_edge  = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_status();
    return (32'(model_ovf) << 7) | (32'(model_q.size() == 0) << 6) | 32'(model_q.size());
  endfunction

  task automatic check_model_regs(input string tag);
    check_output({tag, "_cnt"}, 32'(fifo_cnt), 32'(model_q.size()));
    check_output({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
  endtask

  task automatic apply_stimulus_digit(input string tag);
    logic [31:0] v, exp;
    exp = (model_q.size() == 0) ? 32'hFF : 32'(model_q.pop_front());
    send_cmd(8'h02);
    tick();
    read_bits(8, v);
    check_output(tag, v, exp);
  endtask

  task automatic apply_stimulus_cost(input string tag, input logic [15:0] c);
    logic [31:0] w0, w1;
    cost_in    = c;
    cost_valid = 1'b1;
    send_cmd(8'h01);
    tick();
    read_bits(8, w0);
    read_bits(8, w1);
    check_output({tag, "_hi"}, w0, 32'(c) >> 8);
    check_output({tag, "_lo"}, w1, 32'(c) & 32'hFF);
  endtask

  task automatic apply_stimulus_status(input string tag);
    logic [31:0] v, exp;
    exp = model_status();
    send_cmd(8'h03);
    tick();
    read_bits(8, v);
    check_output(tag, v, exp);
  endtask

  initial begin
    logic [31:0]        v;
    logic [15:0]        c;
    logic [DIGIT_W-1:0] d;

    rst = 1'b1;
    spi.ss_n = 1'b0; spi.shift_spi = 1'b0; spi.sig_edge = 1'b0;
    spi.cmd_in = '0; spi.cmd_valid = 1'b0;
    network_done = 1'b0; digit_in = '0; cost_valid = 1'b0; cost_in = '0;
    repeat (2) tick();
    check_output("rst_miso", 32'(spi.miso), 32'd1);
    check_output("rst_oe", 32'(spi.miso_oe), 32'd0);
    check_output("rst_cnt", 32'(fifo_cnt), 32'd0);
    check_output("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();
    check_output("oe_selected", 32'(spi.miso_oe), 32'd1);

    push_digit(4'h7);
    check_output("push7_cnt", 32'(fifo_cnt), 32'd1);
    apply_stimulus_digit("digit7");
    check_output("digit7_cnt", 32'(fifo_cnt), 32'd0);
    check_output("digit7_idle_miso", 32'(spi.miso), 32'd1);

    apply_stimulus_digit("digit_empty");
    check_output("digit_empty_cnt", 32'(fifo_cnt), 32'd0);

    apply_stimulus_cost("cost_a55a", 16'hA55A);
    check_output("cost_idle_miso", 32'(spi.miso), 32'd1);

    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        push_digit(4'($urandom_range(0, 15)));
      check_model_regs("rand_push");
      case ($urandom_range(0, 2))
        0:       apply_stimulus_digit("rand_digit");
        1:       apply_stimulus_cost("rand_cost", 16'($urandom));
        default: apply_stimulus_status("rand_status");
      endcase
      check_model_regs("rand_after");
    end

    send_cmd(8'h04);
    model_q.delete();
    model_ovf = 1'b0;
    check_model_regs("clr1");

    cost_valid = 1'b0;
    send_cmd(8'h01);
    read_bits(8, v);
    check_output("wait_filler", v, 32'hFF);
    c = 16'($urandom);
    apply_stimulus_cost("after_wait_idle", c);

    c = 16'($urandom);
    cost_in    = c;
    cost_valid = 1'b0;
    send_cmd(8'h01);
    read_bits(3, v);
    check_output("wait_3bits", v, 32'h7);
    cost_valid = 1'b1;
    tick();
    tick();
    read_bits(16, v);
    check_output("late_cost", v, 32'(c));

    for (int k = 0; k < 5; k++) push_digit(4'($urandom_range(0, 15)));
    check_output("ovf_set", 32'(overflow), 32'd1);
    check_output("ovf_cnt", 32'(fifo_cnt), 32'd4);
    apply_stimulus_status("status_full");
    check_output("status_full_const", model_status(), 32'h84);
    send_cmd(8'h04);
    model_q.delete();
    model_ovf = 1'b0;
    check_output("clr_ovf", 32'(overflow), 32'd0);
    check_output("clr_cnt", 32'(fifo_cnt), 32'd0);
    apply_stimulus_status("status_empty");

    for (int k = 0; k < 4; k++) push_digit(4'($urandom_range(0, 15)));
    d = 4'($urandom_range(0, 15));
    v = 32'(model_q.pop_front());
    model_q.push_back(d);
    send_cmd(8'h02);
    network_done = 1'b1;
    digit_in     = d;
    tick();
    network_done = 1'b0;
    begin
      logic [31:0] got;
      read_bits(8, got);
      check_output("pushpop_full", got, v);
    end
    check_model_regs("pushpop_full");
    for (int k = 0; k < 4; k++) apply_stimulus_digit("drain");
    check_model_regs("drained");

    d = 4'($urandom_range(0, 15));
    send_cmd(8'h02);
    network_done = 1'b1;
    digit_in     = d;
    tick();
    network_done = 1'b0;
    read_bits(8, v);
    check_output("pushpop_empty", v, 32'hFF);
    model_q.push_back(d);
    check_model_regs("pushpop_empty");
    apply_stimulus_digit("pushpop_empty_stored");

    c = 16'($urandom);
    cost_in    = c;
    cost_valid = 1'b1;
    send_cmd(8'h01);
    tick();
    read_bits(3, v);
    check_output("abort_3bits", v, 32'(c) >> 13);
    spi.ss_n = 1'b1;
    tick();
    check_output("abort_miso", 32'(spi.miso), 32'd1);
    check_output("abort_oe", 32'(spi.miso_oe), 32'd0);
    spi.ss_n = 1'b0;
    tick();
    apply_stimulus_cost("restart_cost", c);

    push_digit(4'($urandom_range(0, 15)));
    push_digit(4'($urandom_range(0, 15)));
    send_cmd(8'h02);
    tick();
    read_bits(3, v);
    check_output("pre_reset_cnt", 32'(fifo_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check_output("midsend_rst_miso", 32'(spi.miso), 32'd1);
    check_output("midsend_rst_oe", 32'(spi.miso_oe), 32'd0);
    check_output("midsend_rst_cnt", 32'(fifo_cnt), 32'd0);
    tick();
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    tick();
    apply_stimulus_status("post_reset_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
